// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package bus_uart_pkg;

    // Register offsets inside the 4-byte window (AdrIn[1:0])
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV_LO = 2'd2;
    localparam logic [1:0] REG_DIV_HI = 2'd3;

    // STATUS register bit positions
    localparam int ST_FIFO_EMPTY = 0;
    localparam int ST_FIFO_FULL  = 1;
    localparam int ST_BUSY       = 2;
    localparam int ST_OVERFLOW   = 3;
    localparam int ST_PARITY_ON  = 4;

    // Transmit FSM states; PARITY is only entered when parity support is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter. The read port is
// first-word fall-through: rd_data_o shows the head entry whenever not empty.
// A push while full or a pop while empty is ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       push_i,
    input  logic [7:0] wr_data_i,
    input  logic       pop_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU LdMem/WrtMem bus.
// Register window at BASE_ADR: DATA, STATUS, DIV_LO, DIV_HI. Read data is
// registered (1-cycle latency) and is zero on any cycle without a selected load.
// Optional even-parity support is built when BUS_UART_TX_PARITY_EN is defined.
//
// Bus handshake: LdMem/WrtMem are single-cycle strobes with no stall; a
// selected store always completes in its cycle, a selected load always
// returns data on DataOut at the next edge. There is no ready/backpressure.
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADR    = 16'hFF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd1475
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [15:0] AdrIn,
    input  logic [7:0]  DataIn,
    input  logic        LdMem,
    input  logic        WrtMem,
    output logic [7:0]  DataOut,
    output logic        TxD,
    output logic        TxIrq,
    output tx_state_t   dbg_state_o
);

    // Bus decode
    logic       sel;
    logic [1:0] off;
    logic       wr_data_reg;

    // Register file
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  status_val;
    logic [7:0]  rd_val;
`ifdef BUS_UART_TX_PARITY_EN
    logic        parity_on_q, parity_on_d;
    logic        par_q, par_d;
`endif

    // FIFO interface
    logic       fifo_push, fifo_pop;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rd_data;

    // Transmitter
    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tick;
    logic        txd;

    assign sel         = (AdrIn[15:2] == BASE_ADR[15:2]);
    assign off         = AdrIn[1:0];
    assign wr_data_reg = WrtMem & sel & (off == REG_DATA);
    // Full is sampled at the start of the cycle: a same-cycle pop does not make room
    assign fifo_push   = wr_data_reg & ~fifo_full;
    assign tick        = (cnt_q == '0);

    assign DataOut     = data_out_q;
    assign TxD         = txd;
    assign TxIrq       = fifo_empty & (state_q == IDLE);
    assign dbg_state_o = state_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .push_i    (fifo_push),
        .wr_data_i (DataIn),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // STATUS and read-mux assembly from current (pre-write) register values
    always_comb begin
        status_val                = '0;
        status_val[ST_FIFO_EMPTY] = fifo_empty;
        status_val[ST_FIFO_FULL]  = fifo_full;
        status_val[ST_BUSY]       = (state_q != IDLE);
        status_val[ST_OVERFLOW]   = ovf_q;
`ifdef BUS_UART_TX_PARITY_EN
        status_val[ST_PARITY_ON]  = parity_on_q;
`endif
        case (off)
            REG_STATUS: rd_val = status_val;
            REG_DIV_LO: rd_val = div_q[7:0];
            REG_DIV_HI: rd_val = div_q[15:8];
            default:    rd_val = 8'h00;
        endcase
    end

    // Register-file writes, overflow tracking and registered read data
    always_comb begin
        div_d      = div_q;
        ovf_d      = ovf_q;
`ifdef BUS_UART_TX_PARITY_EN
        parity_on_d = parity_on_q;
`endif
        data_out_d = (LdMem & sel) ? rd_val : 8'h00;
        if (WrtMem && sel) begin
            case (off)
                REG_STATUS: begin
                    if (DataIn[ST_OVERFLOW]) begin
                        ovf_d = 1'b0;
                    end
`ifdef BUS_UART_TX_PARITY_EN
                    parity_on_d = DataIn[ST_PARITY_ON];
`endif
                end
                REG_DIV_LO: div_d[7:0]  = DataIn;
                REG_DIV_HI: div_d[15:8] = DataIn;
                default: ;
            endcase
        end
        if (wr_data_reg && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Register-file state
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            div_q      <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
            data_out_q <= 8'h00;
`ifdef BUS_UART_TX_PARITY_EN
            parity_on_q <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
`ifdef BUS_UART_TX_PARITY_EN
            parity_on_q <= parity_on_d;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: every non-idle state lasts exactly one bit time per step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = START;
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick && (bit_idx_q == 3'd7)) begin
`ifdef BUS_UART_TX_PARITY_EN
                    state_d = parity_on_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef BUS_UART_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP:  if (tick) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: line level and FIFO pop (idle fetch or back-to-back at end of stop)
    always_comb begin
        txd      = 1'b1;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE:  fifo_pop = ~fifo_empty;
            START: txd = 1'b0;
            DATA:  txd = shift_q[0];
`ifdef BUS_UART_TX_PARITY_EN
            PARITY: txd = par_q;
`endif
            STOP:  fifo_pop = tick & ~fifo_empty;
            default: txd = 1'b1;
        endcase
    end

    // Shifter and baud counter next values; DIV is only sampled on a reload
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef BUS_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (fifo_pop) begin
            cnt_d     = div_q;
            shift_d   = fifo_rd_data;
            bit_idx_d = 3'd0;
`ifdef BUS_UART_TX_PARITY_EN
            par_d     = ^fifo_rd_data;
`endif
        end else if (state_q != IDLE) begin
            if (tick) begin
                cnt_d = (state_d == IDLE) ? 16'd0 : div_q;
                if (state_q == DATA) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    // Shifter and baud counter registers
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
`ifdef BUS_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
`ifdef BUS_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
